// File: rtl/trdb_itype_pipe.sv
// trdb_itype_pipe: classifies each retired instruction against its successor for trace encoding.
module trdb_itype_pipe #(
  parameter int XLEN     = 32,
  parameter int C_EXT    = 1,
  parameter int IMPL_RET = 1,
  parameter int CALLW    = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            compressed_i,
  input  logic            exception_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_iaddr_o,
  output logic            branch_o,
  output logic            branch_taken_o,
  output logic            updiscon_o,
  output logic            impl_ret_o,
  output logic            last_o,
  output logic [CALLW-1:0] depth_o
);
  logic            h_valid, h_c, h_exc;
  logic [XLEN-1:0] h_addr, h_inst;
  logic [CALLW-1:0] depth, depth_nxt;
  logic is_br, is_c_br, jal, jalr, c_jx, c_jr, c_jalr, rd_link, rs1_link;
  logic jump, call, ret, swap, impl_ret, upd, taken, fire, load;
  logic [4:0] rd, rs1;
  logic unused_bits;
  assign unused_bits = ^h_inst[XLEN-1:20];
  assign rd       = h_inst[11:7];
  assign rs1      = h_inst[19:15];
  assign rd_link  = rd == 5'd1 || rd == 5'd5;
  assign rs1_link = rs1 == 5'd1 || rs1 == 5'd5;
  // 32-bit opcode 0x63 covers the base branches plus the PULP immediate-compare branches
  assign is_c_br  = C_EXT != 0 && h_c && h_inst[1:0] == 2'b01 && h_inst[15:14] == 2'b11;
  assign is_br    = (!h_c && h_inst[6:0] == 7'h63) || is_c_br;
  assign jal      = !h_c && h_inst[6:0] == 7'h6f;
  assign jalr     = !h_c && h_inst[6:0] == 7'h67 && h_inst[14:12] == 3'b000;
  assign c_jx     = C_EXT != 0 && h_c && h_inst[1:0] == 2'b10 && h_inst[15:13] == 3'b100 &&
                    rd != 5'd0 && h_inst[6:2] == 5'd0;
  assign c_jr     = c_jx && !h_inst[12];
  assign c_jalr   = c_jx && h_inst[12];
  assign jump     = jalr || c_jr || c_jalr;
  assign call     = ((jal || jalr) && rd_link) || c_jalr;
  assign ret      = (jalr && rs1_link && rd == 5'd0) || (c_jr && rd_link);
  // link-to-link jalr pops and pushes at once, leaving the depth unchanged
  assign swap     = jalr && rd_link && rs1_link;
  assign impl_ret = IMPL_RET != 0 && ret && depth != '0;
  assign upd      = (jump && !impl_ret) || h_exc;
  assign load     = !stall_i && (flush_i || valid_i);
  assign fire     = load && h_valid;
  assign taken    = is_br && !flush_i && iaddr_i != h_addr + (h_c ? XLEN'(2) : XLEN'(4));
  always_comb
    depth_nxt = (IMPL_RET == 0 || h_exc) ? '0 :
                (call && !swap) ? (&depth ? depth : depth + CALLW'(1)) :
                impl_ret ? depth - CALLW'(1) : depth;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      h_valid        <= 1'b0;
      h_addr         <= '0;
      h_inst         <= '0;
      h_c            <= 1'b0;
      h_exc          <= 1'b0;
      depth          <= '0;
      out_valid_o    <= 1'b0;
      out_iaddr_o    <= '0;
      branch_o       <= 1'b0;
      branch_taken_o <= 1'b0;
      updiscon_o     <= 1'b0;
      impl_ret_o     <= 1'b0;
      last_o         <= 1'b0;
    end else begin
      out_valid_o    <= fire;
      branch_o       <= fire && is_br;
      branch_taken_o <= fire && taken;
      updiscon_o     <= fire && upd;
      impl_ret_o     <= fire && impl_ret;
      last_o         <= fire && flush_i;
      if (fire) begin
        out_iaddr_o <= h_addr;
        depth       <= depth_nxt;
      end
      if (load) begin
        h_valid <= valid_i;
        h_addr  <= iaddr_i;
        h_inst  <= inst_i;
        h_c     <= compressed_i;
        h_exc   <= exception_i;
      end
    end
  assign depth_o = depth;
endmodule
